// File: rtl/win_loss_display.sv
// Win/loss tally display: counts rising edges of the win and lose levels as
// two-digit BCD tallies and scans them onto a 4-digit seven-segment display as WW.LL.
module win_loss_display #(
  parameter int REFRESH_BITS = 17,
  parameter bit BLANK_ZERO   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win,
  input  logic       lose,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  bcd2_t                   win_tally;
  bcd2_t                   lose_tally;
  logic                    win_q;
  logic                    lose_q;
  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              idx;
  logic                    win_pulse;
  logic                    lose_pulse;
  logic [3:0]              digit;
  logic                    blank;
  logic [6:0]              seg_next;

  // 99 wraps to 00; ones >= 9 also folds any out-of-range value back into BCD.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones >= 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens >= 4'd9) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  assign win_pulse  = win & ~win_q;
  assign lose_pulse = lose & ~lose_q;
  assign idx        = cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    digit    = 4'd0;
    seg_next = SEG_BLANK;
    case (idx)
      2'd0:    digit = lose_tally.ones;
      2'd1:    digit = lose_tally.tens;
      2'd2:    digit = win_tally.ones;
      default: digit = win_tally.tens;
    endcase
    blank = BLANK_ZERO && idx[0] && (digit == 4'd0);
    case (digit)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = SEG_BLANK;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_tally  <= '0;
      lose_tally <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      cnt        <= '0;
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      win_q  <= win;
      lose_q <= lose;
      cnt    <= cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      // clr wins over a coincident pulse, which is simply lost.
      if (clr) begin
        win_tally  <= '0;
        lose_tally <= '0;
      end else begin
        if (win_pulse)  win_tally  <= bcd_inc(win_tally);
        if (lose_pulse) lose_tally <= bcd_inc(lose_tally);
      end
      an  <= ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : seg_next;
      dp  <= (idx != 2'd2);
    end
  end

endmodule
